// File: rtl/uart_msg_tx.sv
// ============================================================================
// uart_msg_tx - buffered UART message transmitter with periodic/one-shot start
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_msg_tx #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_RESET = 139,
  parameter int PERIOD    = 8388608
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          div_we,
  input  logic [15:0]   div_di,
  output logic [15:0]   div_do,
  input  logic          buf_we,
  input  logic [AW-1:0] buf_addr,
  input  logic [7:0]    buf_di,
  input  logic [AW:0]   msg_len,
  input  logic          mode,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] char_idx,
  output logic          tx
);

  localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   div_q;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   divl_q, divl_d;
  logic [2:0]    bit_q, bit_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    char_q, char_d;
  logic [TW-1:0] tmr_q;
  logic          done_q, done_d;
  logic          tx_q, tx_d;
  logic [AW:0]   len_clamp;
  logic          trig, bit_end, par_bit;

  logic [7:0]    mem [DEPTH];

  // Buffer is deliberately outside the reset domain so messages survive reset.
  always_ff @(posedge clk) begin
    if (buf_we) mem[buf_addr] <= buf_di;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q <= 16'(DIV_RESET);
      tmr_q <= '0;
    end else begin
      if (div_we) div_q <= (div_di < 16'd2) ? 16'd2 : div_di;
      tmr_q <= (tmr_q == TW'(PERIOD - 1)) ? '0 : tmr_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      divl_q  <= 16'(DIV_RESET);
      bit_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      char_q  <= '0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      divl_q  <= divl_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      char_q  <= char_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    divl_d    = divl_q;
    bit_d     = bit_q;
    idx_d     = idx_q;
    len_d     = len_q;
    char_d    = char_q;
    done_d    = 1'b0;
    len_clamp = (msg_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : msg_len;
    trig      = start || (mode && (tmr_q == TW'(PERIOD - 1)));
    bit_end   = (cnt_q == divl_q - 16'd1);

    if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          if (len_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_START;
            idx_d   = '0;
            len_d   = len_clamp;
            char_d  = mem[0];
            divl_d  = div_q;
            cnt_d   = '0;
          end
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY == 0) ? S_STOP : S_PAR;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_d = '0;
            if ({1'b0, idx_q} == len_q - (AW+1)'(1)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              // Next character picks up the current buffer entry and divider.
              state_d = S_START;
              idx_d   = idx_q + AW'(1);
              char_d  = mem[idx_q + AW'(1)];
              divl_d  = div_q;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    par_bit = (PARITY == 1) ? ~^(char_d & DATA_MASK) : ^(char_d & DATA_MASK);

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = char_d[bit_d];
      S_PAR:   tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  assign div_do   = div_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign char_idx = idx_q;
  assign tx       = tx_q;

endmodule

`default_nettype wire
